// File: rtl/rd_latency_calibrator.sv
// Read-latency calibrator: times training reads from tap 0 to PHY read-valid,
// then steers the matching delay-line tap out as the aligned read-enable.
module rd_latency_calibrator #(
    parameter int WIDTH       = 1,
    parameter int NUM_SAMPLES = 4,
    parameter int CMD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [32*WIDTH-1:0]   i_taps,
    input  logic                  i_rd_valid,
    input  logic                  i_cal_start,
    input  logic                  i_lat_override_en,
    input  logic [4:0]            i_lat_override,
    output logic [WIDTH-1:0]      o_rd_en,
    output logic [4:0]            o_lat,
    output logic                  o_lat_valid,
    output logic                  o_cal_busy,
    output logic                  o_cal_done,
    output logic [1:0]            o_cal_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CMD, S_MEASURE, S_CHECK, S_DONE, S_FAIL
    } state_t;

    localparam logic [9:0] TIMEOUT = 10'(CMD_TIMEOUT);
    localparam logic [3:0] NSAMP   = 4'(NUM_SAMPLES);

    state_t     state_q;
    logic [4:0] meas_cnt_q, meas_cnt_d;
    logic [9:0] to_cnt_q, to_cnt_d;
    logic [3:0] smp_cnt_q, smp_cnt_d;
    logic [4:0] sample_q, ref_q, ref_d;
    logic [4:0] lat_q;
    logic       lat_valid_q, busy_q, done_q;
    logic [1:0] err_q;
    logic [4:0] sel;

    assign meas_cnt_d = meas_cnt_q + 5'd1;
    assign to_cnt_d   = to_cnt_q + 10'd1;
    assign smp_cnt_d  = smp_cnt_q + 4'd1;
    // The first sample of a run becomes the reference it is checked against.
    assign ref_d      = (smp_cnt_q == 4'd0) ? sample_q : ref_q;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        o_rd_en = '0;
        sel     = i_lat_override_en ? i_lat_override : lat_q;
        if (lat_valid_q || i_lat_override_en)
            o_rd_en = i_taps[sel*WIDTH +: WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so all updates take effect together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            meas_cnt_q  <= '0;
            to_cnt_q    <= '0;
            smp_cnt_q   <= '0;
            sample_q    <= '0;
            ref_q       <= '0;
            lat_q       <= '0;
            lat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (i_cal_start) begin
                        state_q     <= S_WAIT_CMD;
                        busy_q      <= 1'b1;
                        lat_valid_q <= 1'b0;
                        done_q      <= 1'b0;
                        err_q       <= 2'd0;
                        smp_cnt_q   <= '0;
                        to_cnt_q    <= '0;
                    end
                end
                S_WAIT_CMD: begin
                    if (i_taps[0]) begin
                        meas_cnt_q <= '0;
                        if (i_rd_valid) begin
                            sample_q <= '0;
                            state_q  <= S_CHECK;
                        end else begin
                            state_q  <= S_MEASURE;
                        end
                    end else if (to_cnt_d == TIMEOUT) begin
                        state_q <= S_FAIL;
                        err_q   <= 2'd1;
                        busy_q  <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                S_MEASURE: begin
                    // meas_cnt_d is the cycle count since the tap-0 pulse.
                    if (i_rd_valid) begin
                        sample_q <= meas_cnt_d;
                        state_q  <= S_CHECK;
                    end else if (meas_cnt_d == 5'd31) begin
                        state_q <= S_FAIL;
                        err_q   <= 2'd2;
                        busy_q  <= 1'b0;
                    end else begin
                        meas_cnt_q <= meas_cnt_d;
                    end
                end
                S_CHECK: begin
                    ref_q <= ref_d;
                    if (smp_cnt_q != 4'd0 && sample_q != ref_q) begin
                        state_q <= S_FAIL;
                        err_q   <= 2'd3;
                        busy_q  <= 1'b0;
                    end else begin
                        smp_cnt_q <= smp_cnt_d;
                        if (smp_cnt_d == NSAMP) begin
                            state_q     <= S_DONE;
                            lat_q       <= ref_d;
                            lat_valid_q <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q  <= S_WAIT_CMD;
                            to_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_lat       = lat_q;
    assign o_lat_valid = lat_valid_q;
    assign o_cal_busy  = busy_q;
    assign o_cal_done  = done_q;
    assign o_cal_err   = err_q;

endmodule

// File: tb/tb_rd_latency_calibrator.sv
// Directed bench for rd_latency_calibrator; models the 32-tap delay line locally.
module tb_rd_latency_calibrator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd = 1'b0;
    logic [31:0] taps = '0;
    logic        rd_valid = 1'b0;
    logic        cal_start = 1'b0;
    logic        ovr_en = 1'b0;
    logic [4:0]  ovr = '0;
    logic [0:0]  rd_en;
    logic [4:0]  lat;
    logic        lat_valid, busy, done;
    logic [1:0]  err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Tap k carries the command delayed k+1 cycles.
    always @(posedge clk) taps <= {taps[30:0], cmd};

    rd_latency_calibrator #(.WIDTH(1), .NUM_SAMPLES(4), .CMD_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .i_taps(taps), .i_rd_valid(rd_valid),
        .i_cal_start(cal_start), .i_lat_override_en(ovr_en), .i_lat_override(ovr),
        .o_rd_en(rd_en), .o_lat(lat), .o_lat_valid(lat_valid), .o_cal_busy(busy),
        .o_cal_done(done), .o_cal_err(err)
    );

    task automatic pulse_start();
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
    endtask

    // One training read: tap-0 pulse, then read-valid lat cycles later (or never).
    task automatic train(input int l, input bit give_valid);
        @(posedge clk); #1 cmd = 1'b1;
        @(posedge clk); #1 cmd = 1'b0;
        if (give_valid) begin
            if (l > 0) begin
                repeat (l) @(posedge clk);
                #1;
            end
            rd_valid = 1'b1;
            @(posedge clk); #1 rd_valid = 1'b0;
        end else begin
            repeat (40) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Sends a command and checks o_rd_en is high only in the cycle the given tap fires.
    task automatic probe_rd_en(input int tap, input string name);
        @(posedge clk); #1 cmd = 1'b1;
        @(posedge clk); #1 cmd = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            total_cnt++;
            if (rd_en !== ((k == tap + 1) ? 1'b1 : 1'b0))
                $display("FAIL %s cycle %0d: rd_en=%b expected %b", name, k, rd_en, (k == tap + 1));
            else pass_cnt++;
        end
    endtask

    task automatic expect_result(input string name, input logic [4:0] e_lat, input logic e_valid,
                                 input logic e_done, input logic [1:0] e_err);
        @(negedge clk);
        total_cnt++;
        if ({busy, lat_valid, done, err, lat} !== {1'b0, e_valid, e_done, e_err, e_lat})
            $display("FAIL %s: busy=%b valid=%b done=%b err=%0d lat=%0d expected busy=0 valid=%b done=%b err=%0d lat=%0d",
                     name, busy, lat_valid, done, err, lat, e_valid, e_done, e_err, e_lat);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({rd_en, lat_valid, err, busy, done, lat} !== 11'd0)
                $display("FAIL reset_idle cycle %0d: outputs=%b expected all zero", i,
                         {rd_en, lat_valid, err, busy, done, lat});
            else pass_cnt++;
        end
    endtask

    task automatic test_cal_basic();
        pulse_start();
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL cal_busy: busy=%b expected 1", busy);
        else pass_cnt++;
        for (int s = 0; s < 4; s++) train(7, 1'b1);
        expect_result("cal_lat7", 5'd7, 1'b1, 1'b1, 2'd0);
        probe_rd_en(7, "align_lat7");
    endtask

    task automatic test_override();
        ovr_en = 1'b1;
        ovr    = 5'd5;
        probe_rd_en(5, "override_tap5");
        ovr_en = 1'b0;
        probe_rd_en(7, "override_off_tap7");
    endtask

    task automatic test_start_ignored();
        pulse_start();
        train(7, 1'b1);
        train(7, 1'b1);
        pulse_start();
        train(7, 1'b1);
        train(7, 1'b1);
        expect_result("start_ignored", 5'd7, 1'b1, 1'b1, 2'd0);
    endtask

    task automatic test_lat_bounds();
        pulse_start();
        for (int s = 0; s < 4; s++) train(0, 1'b1);
        expect_result("lat_zero", 5'd0, 1'b1, 1'b1, 2'd0);
        pulse_start();
        for (int s = 0; s < 4; s++) train(31, 1'b1);
        expect_result("lat_31", 5'd31, 1'b1, 1'b1, 2'd0);
        probe_rd_en(31, "align_lat31");
    endtask

    task automatic test_rd_valid_timeout();
        pulse_start();
        train(0, 1'b0);
        expect_result("rd_valid_timeout", 5'd31, 1'b0, 1'b0, 2'd2);
    endtask

    task automatic test_mismatch();
        pulse_start();
        for (int s = 0; s < 3; s++) train(9, 1'b1);
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL mismatch_busy: busy=%b expected 1", busy);
        else pass_cnt++;
        train(10, 1'b1);
        expect_result("sample_mismatch", 5'd31, 1'b0, 1'b0, 2'd3);
        probe_rd_en(40, "rd_en_off_after_fail");
    endtask

    task automatic test_cmd_timeout();
        int n;
        pulse_start();
        repeat (200) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL cmd_timeout_early: busy=%b expected 1", busy);
        else pass_cnt++;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        expect_result("cmd_timeout", 5'd31, 1'b0, 1'b0, 2'd1);
    endtask

    task automatic test_reset_mid();
        pulse_start();
        @(posedge clk); #1 cmd = 1'b1;
        @(posedge clk); #1 cmd = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if ({rd_en, lat_valid, err, busy, done, lat} !== 11'd0)
            $display("FAIL reset_mid: outputs=%b expected all zero", {rd_en, lat_valid, err, busy, done, lat});
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        repeat (40) @(posedge clk);
        pulse_start();
        for (int s = 0; s < 4; s++) train(4, 1'b1);
        expect_result("cal_after_reset", 5'd4, 1'b1, 1'b1, 2'd0);
        probe_rd_en(4, "align_lat4");
    endtask

    initial begin
        test_reset();
        test_cal_basic();
        test_override();
        test_start_ignored();
        test_lat_bounds();
        test_rd_valid_timeout();
        test_mismatch();
        test_cmd_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rd_latency_calibrator.md
Name: rd_latency_calibrator

Overview:
- Consumes the 32-tap delayed read-command bus produced by the 32-deep tapped delay line.
- Calibrates the round-trip read latency by timing the gap between a training read command (tap 0) and the PHY's returned read-valid.
- Then drives the matching tap as the aligned read-enable toward the read-data capture path.
- Sits between the command-side delay line and the read datapath; a register-override path is provided for bring-up.

Parameters:
- WIDTH, 1, bits per tap; must equal the delay line's WIDTH.
- NUM_SAMPLES, 4, consecutive training reads that must measure the same latency (1..15).
- CMD_TIMEOUT, 255, cycles to wait for a training command on tap 0 before failing (1..1023).

Ports:
- clk  input  1  controller clock.
- rst  input  1  asynchronous, active-high reset.
- i_taps  input  32*WIDTH  delay-line taps; slice k = command input delayed k+1 cycles.
- i_rd_valid  input  1  read-valid returned from PHY.
- i_cal_start  input  1  single-cycle pulse that starts calibration.
- i_lat_override_en  input  1  when 1, tap selection uses i_lat_override.
- i_lat_override  input  5  override tap index.
- o_rd_en  output  WIDTH  selected tap slice (aligned read-enable).
- o_lat  output  5  calibrated tap index.
- o_lat_valid  output  1  o_lat holds a passed calibration.
- o_cal_busy  output  1  calibration in progress.
- o_cal_done  output  1  sticky pass flag.
- o_cal_err  output  2  0 none, 1 cmd timeout, 2 rd_valid timeout, 3 sample mismatch.

Behaviour:
- Reset values:
  - o_lat=0, o_lat_valid=0, o_cal_busy=0, o_cal_done=0, o_cal_err=0.
  - FSM in IDLE; all counters 0.
- Tap select:
  - sel = i_lat_override_en ? i_lat_override : o_lat.
  - o_rd_en = i_taps[sel*WIDTH +: WIDTH] when (o_lat_valid | i_lat_override_en), else 0.
  - Purely combinational; adds 0 cycles beyond the delay line.
- Only lane 0 of tap 0 (i_taps[0]) marks a training command.
- FSM states: IDLE, WAIT_CMD, MEASURE, CHECK, DONE, FAIL.
  - IDLE/DONE/FAIL + i_cal_start:
    - Next cycle -> WAIT_CMD.
    - Set o_cal_busy=1; clear o_lat_valid, o_cal_done, o_cal_err.
    - Clear sample count and timeout counter.
  - WAIT_CMD:
    - i_taps[0]=1 -> MEASURE with meas_cnt=0.
    - If i_rd_valid=1 in the same cycle, the sample is 0 and the FSM goes directly to CHECK.
    - i_rd_valid without a command is ignored.
    - Timeout counter reaching CMD_TIMEOUT -> FAIL, err=1.
  - MEASURE:
    - meas_cnt increments each cycle, counting from 1 on the cycle after the tap-0 pulse.
    - i_rd_valid=1 -> sample=meas_cnt, -> CHECK.
    - meas_cnt would exceed 31 with no valid -> FAIL, err=2.
    - Further tap-0 pulses during MEASURE are ignored.
  - CHECK (1 cycle):
    - First sample is stored as ref.
    - A later sample != ref -> FAIL, err=3.
    - Otherwise increment the sample count.
    - Count == NUM_SAMPLES -> DONE: o_lat=ref, o_lat_valid=1, o_cal_done=1, o_cal_busy=0.
    - Otherwise -> WAIT_CMD with the timeout counter cleared.
  - FAIL: o_cal_busy=0, o_lat_valid=0, o_lat holds its last value, err holds.
- i_cal_start while o_cal_busy=1 is ignored.
- Override is independent of FSM state; o_rd_en follows the override even during calibration.
- Reset mid-calibration: immediate return to IDLE and all reset values, regardless of state.
- Latency rule: a command entering the delay line at cycle c appears on tap 0 at c+1. Valid at c+1+L yields o_lat=L, and slice L then asserts at c+1+L, coincident with read-valid.

Test Plan:
- Reset then idle 10 cycles: o_rd_en=0, o_lat_valid=0, o_cal_err=0, o_cal_busy=0 throughout.
- Start cal, NUM_SAMPLES=4 training commands with i_rd_valid 7 cycles after each tap-0 pulse -> o_lat=7, o_lat_valid=1, o_cal_done=1. A subsequent command makes o_rd_en rise exactly when i_rd_valid does.
- Boundaries:
  - Valid coincident with the tap-0 pulse -> o_lat=0.
  - Valid 31 cycles after -> o_lat=31.
  - Valid absent for 32 cycles -> FAIL, o_cal_err=2.
- Three samples at latency 9 then a fourth at 10 -> FAIL, o_cal_err=3, o_lat_valid=0. No tap-0 pulse for CMD_TIMEOUT cycles after start -> o_cal_err=1.
- Override: i_lat_override_en=1, i_lat_override=5 with o_lat=7 valid -> o_rd_en tracks tap 5. Deassert -> tracks tap 7. A second i_cal_start pulse mid-calibration changes nothing.
- Assert rst during MEASURE -> all outputs return to 0 asynchronously. A fresh calibration after reset passes normally.
